// File: rtl/varredura_display_if.sv
// Digit/strobe inputs and scan outputs of the multiplexed seven-segment driver.
// The master drives the digits; the slave, the display driver, produces the anode and segment lines.
interface varredura_display_if;
    logic [3:0] dezemilhar;
    logic [3:0] milhar;
    logic [3:0] centena;
    logic [3:0] dezena;
    logic [3:0] unidade;
    logic       atualizar;
    logic       apagar_zeros;
    logic [4:0] an;
    logic [6:0] seg;
    logic       quadro_fim;

    modport master (
        output dezemilhar, milhar, centena, dezena, unidade, atualizar, apagar_zeros,
        input  an, seg, quadro_fim
    );

    modport slave (
        input  dezemilhar, milhar, centena, dezena, unidade, atualizar, apagar_zeros,
        output an, seg, quadro_fim
    );
endinterface

// File: rtl/varredura_display.sv
// Five-digit multiplexed seven-segment driver (active-low) with a frame-aligned shadow buffer
// and optional leading-zero blanking.
module varredura_display #(
    parameter int DIVISOR = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    varredura_display_if.slave   bus
);
    localparam int CW = $clog2(DIVISOR);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIVISOR - 1);

    logic [CW-1:0]     cnt;
    logic [2:0]        idx;
    logic [4:0][3:0]   shadow;
    logic [4:0][3:0]   exib;
    logic              pendente;
    logic              quadro_fim_r;
    logic              tick;
    logic              fronteira;
    logic              blank;
    logic [3:0]        dig;

    // Lit pattern bit0=a .. bit6=g (1 = lit), returned inverted for the active-low pins.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] lit;
        case (v)
            4'd0:    lit = 7'b0111111;
            4'd1:    lit = 7'b0000110;
            4'd2:    lit = 7'b1011011;
            4'd3:    lit = 7'b1001111;
            4'd4:    lit = 7'b1100110;
            4'd5:    lit = 7'b1101101;
            4'd6:    lit = 7'b1111101;
            4'd7:    lit = 7'b0000111;
            4'd8:    lit = 7'b1111111;
            4'd9:    lit = 7'b1101111;
            default: lit = 7'b1000000;
        endcase
        return ~lit;
    endfunction

    assign tick      = (cnt == CNT_MAX);
    assign fronteira = tick && (idx == 3'd4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= 3'd0;
            shadow       <= '0;
            exib         <= '0;
            pendente     <= 1'b0;
            quadro_fim_r <= 1'b0;
        end else begin
            cnt          <= tick ? '0 : cnt + 1'b1;
            quadro_fim_r <= fronteira;
            if (tick)
                idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
            if (fronteira && pendente) begin
                exib     <= shadow;
                pendente <= 1'b0;
            end
            // A strobe on the boundary cycle refills shadow and keeps the update pending.
            if (bus.atualizar) begin
                shadow   <= {bus.dezemilhar, bus.milhar, bus.centena, bus.dezena, bus.unidade};
                pendente <= 1'b1;
            end
        end
    end

    always_comb begin
        dig   = exib[idx];
        blank = bus.apagar_zeros && (idx != 3'd0);
        for (int k = 0; k < 5; k++)
            if ((k >= int'(idx)) && (exib[k] != 4'd0))
                blank = 1'b0;
        bus.seg = blank ? 7'b1111111 : seg7(dig);
        bus.an  = ~(5'b00001 << idx);
    end

    assign bus.quadro_fim = quadro_fim_r;
endmodule

// File: tb/tb_varredura_display.sv
// Randomized and directed bench for varredura_display against a cycle-count based reference model.
module tb_varredura_display;
    localparam int D = 4;
    localparam int FRAME = 5 * D;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    varredura_display_if bus ();
    varredura_display #(.DIVISOR(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Reference model: elapsed cycles since reset decide the scan position.
    int n;
    int shadow_m[5];
    int disp_m[5];
    bit pend_m;
    bit qf_m;
    bit az_m;
    logic [19:0] cur_val;

    string segs[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "g", "g", "g", "g", "g", "g"};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int pos);
        logic [6:0] lit;
        string s;
        int top;
        top = 0;
        for (int k = 0; k < 5; k++)
            if (disp_m[k] != 0) top = k;
        if (az_m && pos > top) return 7'b1111111;
        lit = '0;
        s = segs[disp_m[pos]];
        for (int i = 0; i < s.len(); i++)
            lit[int'(s[i]) - 97] = 1'b1;
        return ~lit;
    endfunction

    function automatic logic [4:0] exp_an(input int pos);
        logic [4:0] a;
        a = 5'b11111;
        a[pos] = 1'b0;
        return a;
    endfunction

    task automatic model_reset();
        n = 0;
        pend_m = 0;
        qf_m = 0;
        for (int k = 0; k < 5; k++) begin
            shadow_m[k] = 0;
            disp_m[k] = 0;
        end
    endtask

    task automatic model_step(input logic [19:0] val, input bit at);
        bit bnd;
        bnd = ((n % D) == D - 1) && (((n / D) % 5) == 4);
        if (bnd && pend_m) begin
            disp_m = shadow_m;
            pend_m = 0;
        end
        if (at) begin
            for (int k = 0; k < 5; k++) shadow_m[k] = int'(val[4*k +: 4]);
            pend_m = 1;
        end
        qf_m = bnd;
        n++;
    endtask

    task automatic check_outputs(input string ph);
        int pos;
        pos = (n / D) % 5;
        chk({ph, "_an"}, 32'(bus.an), 32'(exp_an(pos)));
        chk({ph, "_seg"}, 32'(bus.seg), 32'(exp_seg(pos)));
        chk({ph, "_qf"}, 32'(bus.quadro_fim), 32'(qf_m));
    endtask

    task automatic cycle(input logic [19:0] val, input bit at, input bit az, input bit do_rst);
        @(negedge clk);
        check_outputs("pre");
        if (do_rst) begin
            #2 rst = 1'b1;
            #1;
            chk("rst_an", 32'(bus.an), 32'(5'b11110));
            chk("rst_seg", 32'(bus.seg), 32'(7'b1000000));
            chk("rst_qf", 32'(bus.quadro_fim), 32'd0);
            rst = 1'b0;
            model_reset();
        end
        cur_val = val;
        {bus.dezemilhar, bus.milhar, bus.centena, bus.dezena, bus.unidade} = val;
        bus.atualizar = at;
        bus.apagar_zeros = az;
        az_m = az;
        #1;
        chk("live_seg", 32'(bus.seg), 32'(exp_seg((n / D) % 5)));
        model_step(val, at);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) cycle(cur_val, 1'b0, az_m, 1'b0);
    endtask

    task automatic to_boundary();
        while ((n % FRAME) != FRAME - 1) cycle(cur_val, 1'b0, az_m, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        cur_val = '0;
        az_m = 0;
        {bus.dezemilhar, bus.milhar, bus.centena, bus.dezena, bus.unidade} = '0;
        bus.atualizar = 1'b0;
        bus.apagar_zeros = 1'b0;
        model_reset();
        @(negedge clk);
        chk("init_an", 32'(bus.an), 32'(5'b11110));
        chk("init_seg", 32'(bus.seg), 32'(7'b1000000));
        chk("init_qf", 32'(bus.quadro_fim), 32'd0);
        rst = 1'b0;
        model_step(cur_val, 1'b0);

        // Anode walk and frame pulse.
        idle(45);
        // Mid-frame strobe of 1,2,3,4,5.
        idle(3);
        cycle(20'h12345, 1'b1, 1'b0, 1'b0);
        idle(45);
        // Two strobes within one frame; the second wins.
        to_boundary();
        idle(4);
        cycle(20'h00042, 1'b1, 1'b0, 1'b0);
        idle(5);
        cycle(20'h00099, 1'b1, 1'b0, 1'b0);
        idle(45);
        // Strobe exactly on the boundary cycle.
        cycle(20'h00777, 1'b1, 1'b0, 1'b0);
        to_boundary();
        cycle(20'h31415, 1'b1, 1'b0, 1'b0);
        idle(45);
        // Leading-zero blanking, then all zeros, then blanking switched off.
        cycle(20'h00042, 1'b1, 1'b1, 1'b0);
        idle(45);
        cycle(20'h00000, 1'b1, 1'b1, 1'b0);
        idle(42);
        cycle(cur_val, 1'b0, 1'b0, 1'b0);
        idle(22);
        // Invalid code on centena.
        cycle(20'h00C00, 1'b1, 1'b0, 1'b0);
        idle(45);
        // Reset mid-frame with an update pending.
        idle(7);
        cycle(20'h98765, 1'b1, 1'b0, 1'b0);
        idle(3);
        cycle(cur_val, 1'b0, 1'b0, 1'b1);
        idle(45);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [19:0] v;
            bit at, az, r;
            for (int k = 0; k < 5; k++)
                v[4*k +: 4] = ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(15));
            at = ($urandom_range(14) == 0);
            az = ($urandom_range(29) == 0) ? ~az_m : az_m;
            r  = ($urandom_range(499) == 0);
            cycle(v, at, az, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/varredura_display.md
# varredura_display

Multiplexed five-digit seven-segment display driver sitting directly downstream of the binary-to-BCD converter. It consumes the five BCD digits (dezemilhar..unidade) and captures them on an update strobe into a shadow buffer. The buffer is committed to the display only at frame boundaries, so a digit is never torn mid-scan. The block scans one digit at a time with active-low anode and segment outputs, and supports optional leading-zero blanking.

## Interface
- DIVISOR, 50000, clock cycles each digit stays lit (50 MHz clock gives 1 kHz per digit and 200 Hz frame rate); legal range ≥ 2.
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- dezemilhar  input  4  BCD digit 4 (leftmost).
- milhar  input  4  BCD digit 3.
- centena  input  4  BCD digit 2.
- dezena  input  4  BCD digit 1.
- unidade  input  4  BCD digit 0 (rightmost).
- atualizar  input  1  single-cycle strobe that captures all five digits into the shadow buffer.
- apagar_zeros  input  1  1 = blank leading zeros; sampled live, not buffered.
- an  output  5  active-low anode enables; an[k] selects digit k.
- seg  output  7  active-low segments; seg[0]=a … seg[6]=g.
- quadro_fim  output  1  one-cycle pulse on the cycle the scan wraps from digit 4 to digit 0.

One clock; reset is asynchronous and active-high.

## Operation
- Prescaler cnt, width $clog2(DIVISOR), counts 0..DIVISOR-1 and wraps. tick = (cnt == DIVISOR-1).
- Scan index idx runs 0..4. On tick, idx goes to idx+1, except 4 goes to 0. Never takes values 5..7.
- Registers:
  - shadow: 5×4 bits.
  - pendente: 1 bit.
  - exib (displayed digits): 5×4 bits.
- atualizar=1: shadow gets the input digits, pendente is set to 1. Repeated strobes within a frame overwrite shadow; the last one wins.
- Frame boundary (tick with idx==4):
  - If pendente was 1, exib gets the old shadow contents and pendente is cleared.
  - If atualizar is asserted in that same cycle, shadow takes the new inputs and pendente stays 1. That value commits at the next boundary.
- Digit decode of exib[idx], drawn in segments a–g (1 = lit):
  - 0 = abcdef, 1 = bc, 2 = abdeg, 3 = abcdg, 4 = bcfg, 5 = acdfg.
  - 6 = acdefg, 7 = abc, 8 = all, 9 = abcdfg.
  - Codes 10–15 show "-" (g only), seg = 7'b0111111.
- Leading-zero blanking: digit k (k = 1..4) is blank (seg = 7'b1111111, anode still driven) when apagar_zeros=1 and exib[4..k] are all 0. Digit 0 is never blanked.
- an = ~(5'b1 << idx); exactly one anode is low at all times out of reset.
- quadro_fim is registered and high for the single cycle following the boundary tick, i.e. while idx==0 and cnt==0 after a wrap.

## Timing
- Reset values:
  - cnt=0, idx=0, shadow=0, exib=0, pendente=0, quadro_fim=0.
  - an=5'b11110, seg=7'b1000000 (digit "0").
- an and seg are decoded combinationally from the registered idx, exib and apagar_zeros. They change on the same edge as idx.
- Each digit is lit for exactly DIVISOR cycles; a frame is 5×DIVISOR cycles.
- Update latency: a strobe at cycle t appears on the display at the first boundary strictly after t. The worst case is 5×DIVISOR cycles.
- Reset mid-frame returns all state to reset values immediately, independent of clk. Any pending update is discarded.
- apagar_zeros changes take effect on the same cycle, with no frame alignment.

## Test plan
- Reset with DIVISOR=4 → an=11110, seg=1000000, quadro_fim=0. Then idx advances every 4 cycles; an walks 11110→11101→11011→10111→01111→11110. quadro_fim pulses once per 20 cycles.
- Digits 1,2,3,4,5 (dezemilhar..unidade) strobed mid-frame → display stays all "0" until the boundary. Next frame shows digit 0=5 (seg=0010010), digit 4=1 (seg=1111001).
- Two strobes in one frame, values 00042 then 00099 → only 00099 is ever displayed.
- Strobe on the exact boundary cycle → exib receives the previous shadow. The new value appears one frame (20 cycles) later.
- apagar_zeros=1 with 00042 → digits 4..2 have seg=1111111, digit 1=4, digit 0=2. With 00000 only digit 0 lights as "0". Toggling to 0 → all digits show "0" immediately.
- Invalid BCD 4'hC on centena → digit 2 shows seg=0111111. Asserting rst mid-frame → outputs return instantly to reset values and pendente=0.
